// File: rtl/mips_mem_pkg.sv
// Shared constants, state encoding, request payload and byte-lane helpers
// for the MEM-stage load/store unit.
package mips_mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Little-endian lane pick with sign or zero extension.
  function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      size,
                                                   input logic            uns,
                                                   input logic [1:0]      off);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old RAM word with the store data.
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic [1:0]      size,
                                                 input logic [1:0]      off);
    logic [XLEN-1:0] r;
    r = word;
    case (size)
      SIZE_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default:   r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic access_err(input logic [1:0]      size,
                                      input logic            uns,
                                      input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] limit);
    logic misaligned;
    misaligned = ((size == SIZE_HALF) && addr[0]) ||
                 ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    return misaligned || (size == SIZE_RSVD) || ((size == SIZE_WORD) && uns) ||
           (addr >= limit);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: load extract/extend and store lane merge
// against the word currently returned by the data RAM.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  assign load_data_c  = lane_extract(rdata, size, uns, off);
  assign merge_data_c = lane_merge(rdata, wdata, size, off);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-wide RAM without byte
// enables; sub-word stores are performed as read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'd256
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic            ready_d, resp_valid_d, resp_err_d, mem_write_d, mem_read_d;
  logic [XLEN-1:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
  logic [XLEN-1:0] load_data_c, merge_data_c;
  logic            accept_c, req_err_c, needs_read_c;

  assign accept_c     = req_valid && req_ready;
  assign req_err_c    = access_err(req_size, req_unsigned, req_addr, ADDR_LIMIT);
  assign needs_read_c = !req_we || (req_size != SIZE_WORD);

  lsu_lane_align u_align (
    .size         (req_q.size),
    .uns          (req_q.uns),
    .off          (req_q.off),
    .wdata        (req_q.wdata),
    .rdata        (mem_rdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          ready_d = 1'b0;
          req_d   = '{we: req_we, size: req_size, uns: req_unsigned,
                      off: req_addr[1:0], wdata: req_wdata};
          if (req_err_c) begin
            state_d = ST_ERR;
          end else begin
            mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
            if (needs_read_c) begin
              state_d    = ST_READ;
              mem_read_d = 1'b1;
            end else begin
              state_d     = ST_WRITE;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d     = ST_WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = merge_data_c;
        end else begin
          state_d      = ST_IDLE;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data_c;
        end
      end
      ST_WRITE: begin
        state_d      = ST_IDLE;
        ready_d      = 1'b1;
        resp_valid_d = 1'b1;
      end
      ST_ERR: begin
        state_d      = ST_IDLE;
        ready_d      = 1'b1;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_ready  <= ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-array memory model, directed
// scenarios, back-to-back loads, async reset mid-store and randomized traffic.
module tb_load_store_unit;

  // {err, rdata, latency, reads, writes, written word, strobe address}
  typedef logic [104:0] obs_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] spec;
  } op_t;

  logic        clock, reset_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [31:0] ram [0:63];
  logic [31:0] init_words [0:63];
  logic        ram_loaded;
  logic [7:0]  ref_bytes [0:255];

  int vectors;
  int miscompares;

  load_store_unit #(.ADDR_LIMIT(32'd256)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data RAM: read data registered on the falling edge, writes commit on the rising edge.
  always @(negedge clock) if (mem_read) mem_rdata <= ram[mem_addr[7:2]];
  always @(posedge clock) begin
    if (!ram_loaded) for (int i = 0; i < 64; i++) ram[i] <= init_words[i];
    else if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;
  end

  function automatic logic m_err(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    int unsigned n = 1 << size;
    return (size == 2'd3) || ((addr % n) != 0) || (uns && size == 2'd2) || (addr >= 32'd256);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    int unsigned n = 1 << size;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < int'(n); i++) v |= 32'(ref_bytes[addr[7:0] + 8'(i)]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic void m_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned n = 1 << size;
    for (int i = 0; i < int'(n); i++) ref_bytes[addr[7:0] + 8'(i)] = 8'(wdata >> (8 * i));
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] addr);
    logic [7:0] a = {addr[7:2], 2'b00};
    return {ref_bytes[a + 8'd3], ref_bytes[a + 8'd2], ref_bytes[a + 8'd1], ref_bytes[a]};
  endfunction

  // Expected observation of one operation; stores also update the model memory.
  function automatic obs_t m_op(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
    logic        e;
    logic [31:0] rd = 32'd0, ww = 32'd0, ma = 32'd0;
    int          lat = 2, nr = 0, nw = 0;
    e = m_err(size, uns, addr);
    if (!e && !we) begin
      rd = m_load(size, uns, addr);
      nr = 1;
      ma = {addr[31:2], 2'b00};
    end else if (!e) begin
      m_store(size, addr, wdata);
      ww  = m_word(addr);
      nw  = 1;
      nr  = (size == 2'd2) ? 0 : 1;
      lat = 2 + nr;
      ma  = {addr[31:2], 2'b00};
    end
    return {e, rd, 4'(lat), 2'(nr), 2'(nw), ww, ma};
  endfunction

  // Issue one request starting at a falling edge; returns at the falling edge where resp_valid is seen.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output obs_t got);
    int          guard = 0, lat = 1, nr = 0, nw = 0;
    logic        err = 1'b0;
    logic [31:0] rd = 32'd0, ww = 32'd0, ma = 32'd0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    forever begin
      if (mem_read === 1'b1)  begin nr++; ma = mem_addr; end
      if (mem_write === 1'b1) begin nw++; ww = mem_wdata; ma = mem_addr; end
      if (resp_valid === 1'b1) begin err = resp_err; rd = resp_rdata; break; end
      if (lat >= 8) begin
        vectors++; miscompares++;
        $display("FAIL resp_timeout addr=%h got no resp_valid within %0d cycles, required within 3", addr, lat);
        break;
      end
      @(negedge clock);
      lat++;
    end
    got = {err, rd, 4'(lat), 2'(nr), 2'(nw), (nw > 0) ? ww : 32'd0, (nr + nw > 0) ? ma : 32'd0};
  endtask

  task automatic test_reset;
    logic [100:0] obs;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    ram_loaded = 1'b1;
    obs = {req_ready, resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_addr, mem_wdata};
    vectors++;
    if (obs !== {1'b1, 100'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h required=%h", obs, {1'b1, 100'd0});
    end
    reset_n = 1'b1;
    @(negedge clock);
    obs = {req_ready, resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_addr, mem_wdata};
    vectors++;
    if (obs !== {1'b1, 100'd0}) begin
      miscompares++;
      $display("FAIL reset_release_idle got=%h required=%h", obs, {1'b1, 100'd0});
    end
  endtask

  task automatic test_word_access;
    op_t ops [0:1];
    obs_t got, exp;
    logic [31:0] v;
    ops[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    ops[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF};
    foreach (ops[i]) begin
      exp = m_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata);
      run_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, got);
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL word_access[%0d] got=%h expected=%h", i, got, exp); end
      if (ops[i].chk) begin
        v = ops[i].we ? got[63:32] : got[103:72];
        vectors++;
        if (v !== ops[i].spec) begin miscompares++; $display("FAIL word_access_value[%0d] got=%h expected=%h", i, v, ops[i].spec); end
      end
    end
  endtask

  task automatic test_subword_rmw;
    op_t ops [0:5];
    obs_t got, exp;
    logic [31:0] v;
    ops[0] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b1, 32'hDEADAAEF};
    ops[1] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        1'b1, 32'hFFFFFFAA};
    ops[2] = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b1, 32'h000000AA};
    ops[3] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE1234, 1'b1, 32'h1234AAEF};
    ops[4] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b1, 32'h00001234};
    ops[5] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b1, 32'h1234AAEF};
    foreach (ops[i]) begin
      exp = m_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata);
      run_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, got);
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL subword[%0d] got=%h expected=%h", i, got, exp); end
      if (ops[i].chk) begin
        v = ops[i].we ? got[63:32] : got[103:72];
        vectors++;
        if (v !== ops[i].spec) begin miscompares++; $display("FAIL subword_value[%0d] got=%h expected=%h", i, v, ops[i].spec); end
      end
    end
  endtask

  task automatic test_errors;
    op_t ops [0:9];
    obs_t got, exp;
    ops[0] = '{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,  1'b1, 32'h0};
    ops[1] = '{1'b0, 2'd3, 1'b0, 32'h20,  32'h0,  1'b0, 32'h0};
    ops[2] = '{1'b1, 2'd3, 1'b0, 32'h24,  32'h55, 1'b0, 32'h0};
    ops[3] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,  1'b0, 32'h0};
    ops[4] = '{1'b1, 2'd0, 1'b0, 32'h100, 32'h77, 1'b0, 32'h0};
    ops[5] = '{1'b0, 2'd2, 1'b1, 32'h20,  32'h0,  1'b0, 32'h0};
    ops[6] = '{1'b1, 2'd1, 1'b0, 32'h21,  32'h1,  1'b0, 32'h0};
    ops[7] = '{1'b1, 2'd2, 1'b0, 32'h22,  32'h2,  1'b0, 32'h0};
    ops[8] = '{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,  1'b0, 32'h0};
    ops[9] = '{1'b0, 2'd0, 1'b0, 32'hFF,  32'h0,  1'b0, 32'h0};
    foreach (ops[i]) begin
      exp = m_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata);
      run_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, got);
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL errors[%0d] got=%h expected=%h", i, got, exp); end
      if (ops[i].chk) begin
        vectors++;
        if (got[104:72] !== {1'b1, ops[i].spec}) begin
          miscompares++; $display("FAIL errors_flag[%0d] got=%h expected=%h", i, got[104:72], {1'b1, ops[i].spec});
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [0:3];
    logic [31:0] exp_rd [0:3];
    logic [31:0] rd [0:3];
    int acc_cyc [0:3];
    int resp_cyc [0:3];
    obs_t e;
    int i = 0, k = 0, c = 0;
    logic acc;
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'hFC; addrs[3] = 32'h00;
    for (int j = 0; j < 4; j++) begin
      e = m_op(1'b0, 2'd2, 1'b0, addrs[j], 32'd0);
      exp_rd[j] = e[103:72];
    end
    @(negedge clock);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'd0;
    req_addr = addrs[0]; req_valid = 1'b1;
    while (k < 4 && c < 40) begin
      if (resp_valid === 1'b1) begin resp_cyc[k] = c; rd[k] = resp_rdata; k++; end
      acc = (req_valid === 1'b1) && (req_ready === 1'b1);
      @(posedge clock); c++;
      @(negedge clock);
      if (acc && i < 4) begin
        acc_cyc[i] = c; i++;
        if (i < 4) req_addr = addrs[i]; else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (k != 4) begin miscompares++; $display("FAIL b2b_resp_count got=%0d required=4", k); end
    for (int j = 0; j < k; j++) begin
      vectors++;
      if (rd[j] !== exp_rd[j]) begin miscompares++; $display("FAIL b2b_rdata[%0d] got=%h expected=%h", j, rd[j], exp_rd[j]); end
    end
    for (int j = 1; j < k; j++) begin
      vectors++;
      if (resp_cyc[j] - resp_cyc[j-1] != 2) begin
        miscompares++; $display("FAIL b2b_spacing[%0d] got=%0d required=2", j, resp_cyc[j] - resp_cyc[j-1]);
      end
      vectors++;
      if (j < i && acc_cyc[j] != resp_cyc[j-1] + 1) begin
        miscompares++; $display("FAIL b2b_accept[%0d] got edge %0d required edge %0d", j, acc_cyc[j], resp_cyc[j-1] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    obs_t got, exp;
    logic [100:0] obs;
    logic saw_resp = 1'b0;
    int guard = 0;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = $urandom;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    vectors++;
    if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rst_mid_read_phase got mem_read=%b required=1", mem_read); end
    @(negedge clock);
    vectors++;
    if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rst_mid_write_phase got mem_write=%b required=1", mem_write); end
    #1 reset_n = 1'b0;
    #1;
    obs = {req_ready, resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_addr, mem_wdata};
    vectors++;
    if (obs !== {1'b1, 100'd0}) begin miscompares++; $display("FAIL rst_mid_async_clear got=%h required=%h", obs, {1'b1, 100'd0}); end
    repeat (2) begin @(negedge clock); if (resp_valid !== 1'b0) saw_resp = 1'b1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clock); if (resp_valid !== 1'b0) saw_resp = 1'b1; end
    vectors++;
    if (saw_resp !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_resp got resp pulse=%b required=0", saw_resp); end
    exp = m_op(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, got);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_mid_reread got=%h expected=%h", got, exp); end
  endtask

  task automatic test_random;
    obs_t got, exp;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    for (int n = 0; n < 200; n++) begin
      we    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns   = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = 32'(256 + $urandom_range(0, 64));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      exp = m_op(we, size, uns, addr, wdata);
      run_op(we, size, uns, addr, wdata, got);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] we=%b size=%0d uns=%b addr=%h got=%h expected=%h", n, we, size, uns, addr, got, exp);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; ram_loaded = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      init_words[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = init_words[i][8*b +: 8];
    end
    test_reset;
    test_word_access;
    test_subword_rmw;
    test_errors;
    test_back_to_back;
    test_reset_mid_write;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
